// File: rtl/fma_write_buffer.sv
// fma_write_buffer
// Collects one result word from each FMA. Once every FMA has reported, the
// words form a result set, which is committed into a packed line that holds
// the last DEPTH sets. Slot 1 (the newest set) sits in the least significant
// bits of line_out. The memory block consumes line_out through its write
// buffer inputs and acknowledges with read_ack_in.
//
// Optional feature macro: WRITE_BUFFER_BYPASS_EN
//   When defined, a commit is forwarded combinationally onto
//   line_out/line_valid_out in the same cycle (zero latency).
//   When undefined, the outputs are registered (one cycle of latency).
//
// DEPTH must be at least 2, because the history shift slices off the oldest slot.
module fma_write_buffer #(
    parameter int FMA_COUNT   = 2,
    parameter int WORD_WIDTH  = 16,
    parameter int DEPTH       = 3,
    parameter int LINE_WIDTH  = FMA_COUNT * DEPTH * WORD_WIDTH,
    parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [FMA_COUNT*WORD_WIDTH-1:0] fma_c_in,
    input  logic [FMA_COUNT-1:0]            fma_valid_in,
    input  logic                            flush_in,
    input  logic                            read_ack_in,
    output logic [LINE_WIDTH-1:0]           line_out,
    output logic                            line_valid_out,
    output logic [COUNT_WIDTH-1:0]          count_out,
    output logic                            overflow_out,
    output logic                            dup_error_out
);

    localparam int SET_WIDTH = FMA_COUNT * WORD_WIDTH;
    localparam logic [COUNT_WIDTH-1:0] DEPTH_C = COUNT_WIDTH'(DEPTH);

    logic [SET_WIDTH-1:0]   capture_q, capture_d;
    logic [FMA_COUNT-1:0]   got_q, got_d;
    logic [LINE_WIDTH-1:0]  line_q, line_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   dup_q, dup_d;

    logic [SET_WIDTH-1:0]   newSet;
    logic [LINE_WIDTH-1:0]  shiftedLine;
    logic                   commit;
    logic                   ackEffective;
    logic                   dupHit;

    // Merge this cycle's valid words over the held captures, and detect when the set is complete.
    always_comb begin
        newSet = capture_q;
        for (int f = 0; f < FMA_COUNT; f++) begin
            if (fma_valid_in[f]) begin
                newSet[f*WORD_WIDTH +: WORD_WIDTH] = fma_c_in[f*WORD_WIDTH +: WORD_WIDTH];
            end
        end
        commit       = (&(got_q | fma_valid_in)) && !flush_in;
        shiftedLine  = {line_q[LINE_WIDTH-SET_WIDTH-1:0], newSet};
        ackEffective = read_ack_in && (count_q != '0);
        dupHit       = |(got_q & fma_valid_in);
    end

    // Next-state logic; a flush overrides capture, commit and ack.
    always_comb begin
        capture_d  = newSet;
        got_d      = got_q | fma_valid_in;
        line_d     = line_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        dup_d      = dup_q | dupHit;
        if (flush_in) begin
            capture_d  = '0;
            got_d      = '0;
            line_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            dup_d      = 1'b0;
        end else begin
            if (commit) begin
                got_d  = '0;
                line_d = shiftedLine;
                if (ackEffective) begin
                    count_d = COUNT_WIDTH'(1);
                end else if (count_q == DEPTH_C) begin
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else if (ackEffective) begin
                count_d = '0;
            end
        end
    end

    // State registers with asynchronous reset that discards any partial set.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            capture_q  <= '0;
            got_q      <= '0;
            line_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            dup_q      <= 1'b0;
        end else begin
            capture_q  <= capture_d;
            got_q      <= got_d;
            line_q     <= line_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            dup_q      <= dup_d;
        end
    end

    // Output drive: either registered only, or with a same-cycle forward of the committing line.
`ifdef WRITE_BUFFER_BYPASS_EN
    always_comb begin
        line_out       = commit ? shiftedLine : line_q;
        line_valid_out = commit || (count_q != '0);
    end
`else
    always_comb begin
        line_out       = line_q;
        line_valid_out = (count_q != '0);
    end
`endif

    assign count_out     = count_q;
    assign overflow_out  = overflow_q;
    assign dup_error_out = dup_q;

endmodule

// File: tb/tb_fma_write_buffer.sv
// tb_fma_write_buffer
// Randomized and directed stimulus for fma_write_buffer. The expected
// outputs come from a behavioural model that holds the committed sets in a
// queue, with the newest set at the front.
module tb_fma_write_buffer;

   localparam int FMA_COUNT  = 2;
   localparam int WORD_WIDTH = 16;
   localparam int DEPTH      = 3;
   localparam int LINE_WIDTH = FMA_COUNT * DEPTH * WORD_WIDTH;
   localparam int SET_WIDTH  = FMA_COUNT * WORD_WIDTH;
   localparam int CW         = $clog2(DEPTH + 1);

   logic                  clk_in = 1'b0;
   logic                  rst_in;
   logic [SET_WIDTH-1:0]  fma_c_in;
   logic [FMA_COUNT-1:0]  fma_valid_in;
   logic                  flush_in;
   logic                  read_ack_in;
   logic [LINE_WIDTH-1:0] line_out;
   logic                  line_valid_out;
   logic [CW-1:0]         count_out;
   logic                  overflow_out;
   logic                  dup_error_out;

   int checkCount = 0;
   int errorCount = 0;

   // Reference model state
   logic [WORD_WIDTH-1:0] modelCap [FMA_COUNT];
   bit   [FMA_COUNT-1:0]  modelGot;
   logic [SET_WIDTH-1:0]  histQ [$];
   int                    modelCount;
   bit                    modelOverflow;
   bit                    modelDup;

   logic [LINE_WIDTH-1:0] savedLine;

   fma_write_buffer dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .fma_c_in      (fma_c_in),
      .fma_valid_in  (fma_valid_in),
      .flush_in      (flush_in),
      .read_ack_in   (read_ack_in),
      .line_out      (line_out),
      .line_valid_out(line_valid_out),
      .count_out     (count_out),
      .overflow_out  (overflow_out),
      .dup_error_out (dup_error_out)
   );

   // Free-running clock with a 10-unit period
   always #5 clk_in = ~clk_in;

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      for (int f = 0; f < FMA_COUNT; f++) modelCap[f] = '0;
      modelGot      = '0;
      histQ.delete();
      modelCount    = 0;
      modelOverflow = 0;
      modelDup      = 0;
   endtask

   function automatic logic [LINE_WIDTH-1:0] expectedLine();
      logic [LINE_WIDTH-1:0] l = '0;
      for (int s = 0; s < histQ.size(); s++) l[s*SET_WIDTH +: SET_WIDTH] = histQ[s];
      return l;
   endfunction

   // One clock edge of the reference model, applied with the inputs that were held across the edge
   task automatic modelUpdate(input logic [FMA_COUNT-1:0] v, input logic [SET_WIDTH-1:0] c,
                              input bit flush, input bit ack);
      bit committed = 0;
      bit ackEff;
      logic [SET_WIDTH-1:0] setVal;
      if (flush) begin
         histQ.delete();
         modelGot = '0;
         modelCount = 0;
         modelOverflow = 0;
         modelDup = 0;
         return;
      end
      ackEff = ack && (modelCount != 0);
      for (int f = 0; f < FMA_COUNT; f++) begin
         if (v[f]) begin
            if (modelGot[f]) modelDup = 1;
            modelCap[f] = c[f*WORD_WIDTH +: WORD_WIDTH];
            modelGot[f] = 1;
         end
      end
      if (modelGot == {FMA_COUNT{1'b1}}) begin
         for (int f = 0; f < FMA_COUNT; f++) setVal[f*WORD_WIDTH +: WORD_WIDTH] = modelCap[f];
         histQ.push_front(setVal);
         if (histQ.size() > DEPTH) void'(histQ.pop_back());
         modelGot = '0;
         committed = 1;
      end
      if (committed) begin
         if (ackEff) modelCount = 1;
         else if (modelCount == DEPTH) modelOverflow = 1;
         else modelCount++;
      end else if (ackEff) begin
         modelCount = 0;
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".line"},     128'(line_out),       128'(expectedLine()));
      checkOutput({tag, ".valid"},    128'(line_valid_out), 128'(modelCount != 0));
      checkOutput({tag, ".count"},    128'(count_out),      128'(modelCount));
      checkOutput({tag, ".overflow"}, 128'(overflow_out),   128'(modelOverflow));
      checkOutput({tag, ".dup"},      128'(dup_error_out),  128'(modelDup));
   endtask

   task automatic idleInputs();
      fma_valid_in = '0;
      fma_c_in     = '0;
      flush_in     = 1'b0;
      read_ack_in  = 1'b0;
   endtask

   // Drive one cycle of inputs, advance the model at the edge, then check the registered view
   task automatic applyStimulus(input string tag, input logic [FMA_COUNT-1:0] v, input logic [SET_WIDTH-1:0] c,
                                input bit flush, input bit ack);
      fma_valid_in = v;
      fma_c_in     = c;
      flush_in     = flush;
      read_ack_in  = ack;
      @(posedge clk_in);
      modelUpdate(v, c, flush, ack);
      #1;
      idleInputs();
      #1;
      checkAll(tag);
   endtask

   initial begin
      idleInputs();
      modelReset();
      rst_in = 1'b1;
      #12;
      checkAll("reset");
      rst_in = 1'b0;
      @(posedge clk_in);
      #1;

      // Both FMAs in one cycle
      applyStimulus("both", 2'b11, 32'h0800_0400, 0, 0);
      checkOutput("both.slot1", 128'(line_out[31:0]), 128'(32'h0800_0400));
      checkOutput("both.count1", 128'(count_out), 128'd1);

      // Split arrival over three cycles
      applyStimulus("split0", 2'b01, 32'h0000_0001, 0, 0);
      applyStimulus("split1", 2'b00, 32'h0, 0, 0);
      checkOutput("split.nocommit", 128'(count_out), 128'd1);
      applyStimulus("split2", 2'b10, 32'h0002_0000, 0, 0);
      checkOutput("split.slot1", 128'(line_out[31:0]), 128'(32'h0002_0001));

      // Fill past DEPTH without ack
      applyStimulus("fillC", 2'b11, 32'hCCCC_0C0C, 0, 0);
      applyStimulus("fillD", 2'b11, 32'hDDDD_0D0D, 0, 0);
      checkOutput("fill.slot1", 128'(line_out[31:0]),  128'(32'hDDDD_0D0D));
      checkOutput("fill.slot2", 128'(line_out[63:32]), 128'(32'hCCCC_0C0C));
      checkOutput("fill.slot3", 128'(line_out[95:64]), 128'(32'h0002_0001));
      checkOutput("fill.count", 128'(count_out), 128'd3);
      checkOutput("fill.overflow", 128'(overflow_out), 128'd1);

      // Ack together with a commit, then ack alone
      applyStimulus("ackCommit", 2'b11, 32'h1234_5678, 0, 1);
      checkOutput("ackCommit.count", 128'(count_out), 128'd1);
      checkOutput("ackCommit.valid", 128'(line_valid_out), 128'd1);
      savedLine = line_out;
      applyStimulus("ackAlone", 2'b00, 32'h0, 0, 1);
      checkOutput("ackAlone.valid", 128'(line_valid_out), 128'd0);
      checkOutput("ackAlone.line", 128'(line_out), 128'(savedLine));
      applyStimulus("ackIdle", 2'b00, 32'h0, 0, 1);

      // Duplicate report before the set completes, then flush
      applyStimulus("dup0", 2'b01, 32'h0000_AAAA, 0, 0);
      applyStimulus("dup1", 2'b01, 32'h0000_BBBB, 0, 0);
      checkOutput("dup.flag", 128'(dup_error_out), 128'd1);
      applyStimulus("dup2", 2'b10, 32'hCCCC_0000, 0, 0);
      checkOutput("dup.slot1", 128'(line_out[31:0]), 128'(32'hCCCC_BBBB));
      applyStimulus("flush", 2'b11, 32'hFFFF_FFFF, 1, 1);
      checkOutput("flush.line", 128'(line_out), 128'd0);
      checkOutput("flush.count", 128'(count_out), 128'd0);

`ifdef WRITE_BUFFER_BYPASS_EN
      // Same-cycle forward of a commit
      fma_valid_in = 2'b11;
      fma_c_in     = 32'h0800_0400;
      #1;
      checkOutput("bypass.valid", 128'(line_valid_out), 128'd1);
      checkOutput("bypass.slot1", 128'(line_out[31:0]), 128'(32'h0800_0400));
      @(posedge clk_in);
      modelUpdate(2'b11, 32'h0800_0400, 0, 0);
      #1;
      idleInputs();
      #1;
      checkAll("bypass.after");
`endif

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         applyStimulus("rand", FMA_COUNT'($urandom_range(0, 3)), SET_WIDTH'($urandom),
                       $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0);
      end

      // Asynchronous reset in the middle of a set
      applyStimulus("preRst", 2'b11, 32'h5555_AAAA, 0, 0);
      applyStimulus("partial", 2'b01, 32'h0000_7777, 0, 0);
      rst_in = 1'b1;
      #1;
      modelReset();
      checkOutput("asyncRst.line", 128'(line_out), 128'd0);
      checkOutput("asyncRst.valid", 128'(line_valid_out), 128'd0);
      checkAll("asyncRst");
      #2;
      rst_in = 1'b0;
      applyStimulus("postRst", 2'b10, 32'h9999_0000, 0, 0);
      checkOutput("postRst.nocommit", 128'(line_valid_out), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
